display_frame_scheduler: RTL and testbench

//   Shares the 4-digit serial display path between two BCD requesters.

---
 rtl/display_frame_scheduler.sv | 166 ++++++++++++++++
 tb/tb_display_frame_scheduler.sv | 552 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_frame_scheduler.sv
// Display frame scheduler: round-robin arbiter for two BCD requesters that
// share one 4-digit serializer. It latches the granted value, enables the
// serializer on bit ticks, acks on frame end, aborts frames that stall and
// enforces an inter-frame gap.
// Optional feature: define DISP_SCHED_REFRESH_EN to re-send the last value
// after REFRESH_TICKS idle ticks with no request pending.
module display_frame_scheduler #(
  parameter int unsigned GAP_TICKS     = 8,
  parameter int unsigned TIMEOUT_TICKS = 256
`ifdef DISP_SCHED_REFRESH_EN
  ,
  parameter int unsigned REFRESH_TICKS = 4096
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [1:0]  req,
  input  logic [15:0] bcd0,
  input  logic [15:0] bcd1,
  input  logic        busy_in,
  output logic [1:0]  ack,
  output logic [15:0] bcd_out,
  output logic        shift_en,
  output logic        active_src,
  output logic        timeout_err
);

  localparam logic [15:0] GapLim     = 16'(GAP_TICKS);
  localparam logic [15:0] TimeoutLim = 16'(TIMEOUT_TICKS);
`ifdef DISP_SCHED_REFRESH_EN
  localparam logic [15:0] RefreshLim = 16'(REFRESH_TICKS);
`endif

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StGap} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;
  logic [15:0] bcd_q, bcd_d;
  logic        src_q, src_d;
  logic [1:0]  ack_q, ack_d;
  logic        terr_q, terr_d;
  logic        gnt_src;
`ifdef DISP_SCHED_REFRESH_EN
  logic [15:0] idle_q, idle_d;
  logic [15:0] idle_inc;
  logic        refresh_q, refresh_d;
`endif

  // Counters saturate instead of wrapping.
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
`ifdef DISP_SCHED_REFRESH_EN
  assign idle_inc = (idle_q == 16'hFFFF) ? idle_q : idle_q + 16'd1;
`endif

  // A lone requester wins outright; with both pending, alternate away from the last grant.
  assign gnt_src = (req == 2'b11) ? ~src_q : req[1];

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    src_d   = src_q;
    ack_d   = 2'b00;
    terr_d  = 1'b0;
`ifdef DISP_SCHED_REFRESH_EN
    idle_d    = idle_q;
    refresh_d = refresh_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (req != 2'b00) begin
          state_d = StLoad;
          src_d   = gnt_src;
          bcd_d   = gnt_src ? bcd1 : bcd0;
`ifdef DISP_SCHED_REFRESH_EN
          idle_d    = '0;
          refresh_d = 1'b0;
`endif
        end
`ifdef DISP_SCHED_REFRESH_EN
        else if (idle_q >= RefreshLim) begin
          // Internal re-send: keep bcd_out and active_src, suppress the ack.
          state_d   = StLoad;
          idle_d    = '0;
          refresh_d = 1'b1;
        end else if (tick) begin
          idle_d = idle_inc;
        end
`endif
      end
      StLoad: begin
        if (tick && (cnt_inc >= TimeoutLim)) begin
          state_d = StGap;
          cnt_d   = '0;
          terr_d  = 1'b1;
        end else begin
          if (tick) cnt_d = cnt_inc;
          if (busy_in) state_d = StSend;
        end
      end
      StSend: begin
        if (!busy_in) begin
          state_d = StGap;
          cnt_d   = '0;
`ifdef DISP_SCHED_REFRESH_EN
          ack_d[src_q] = ~refresh_q;
`else
          ack_d[src_q] = 1'b1;
`endif
        end else if (tick && (cnt_inc >= TimeoutLim)) begin
          state_d = StGap;
          cnt_d   = '0;
          terr_d  = 1'b1;
        end else if (tick) begin
          cnt_d = cnt_inc;
        end
      end
      StGap: begin
        if (cnt_q >= GapLim) begin
          state_d = StIdle;
        end else if (tick) begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bcd_q   <= '0;
      src_q   <= 1'b1;
      ack_q   <= 2'b00;
      terr_q  <= 1'b0;
`ifdef DISP_SCHED_REFRESH_EN
      idle_q    <= '0;
      refresh_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      src_q   <= src_d;
      ack_q   <= ack_d;
      terr_q  <= terr_d;
`ifdef DISP_SCHED_REFRESH_EN
      idle_q    <= idle_d;
      refresh_q <= refresh_d;
`endif
    end
  end

  assign ack         = ack_q;
  assign bcd_out     = bcd_q;
  assign active_src  = src_q;
  assign timeout_err = terr_q;
  assign shift_en    = tick & ((state_q == StLoad) | (state_q == StSend));

endmodule

// File: tb/tb_display_frame_scheduler.sv
// Self-checking bench for display_frame_scheduler: scoreboard of expected acks,
// a behavioural serializer and an output monitor that logs events.
module tb_display_frame_scheduler;

  localparam int unsigned GapTicks     = 8;
  localparam int unsigned TimeoutTicks = 256;
  localparam int unsigned TickDiv      = 4;

  logic        clk;
  logic        reset;
  logic        tick;
  logic [1:0]  req;
  logic [15:0] bcd0;
  logic [15:0] bcd1;
  logic        busy_in;
  logic [1:0]  ack;
  logic [15:0] bcd_out;
  logic        shift_en;
  logic        active_src;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  ack;
    logic [15:0] bcd;
  } exp_t;

  typedef struct {
    logic [1:0]  ack;
    logic        src;
    logic [15:0] bcd;
    int unsigned tick_idx;
  } obs_t;

  exp_t        exp_q[$];
  obs_t        obs_q[$];
  int unsigned terr_q[$];

  int unsigned tick_cnt        = 0;
  int unsigned tick_div        = 0;
  int unsigned shift_cnt       = 0;
  int unsigned last_shift_tick = 0;
  int unsigned stray_shift     = 0;
  int unsigned ack_long        = 0;
  int unsigned terr_long       = 0;
  logic [1:0]  ack_prev;
  logic        terr_prev;

  bit          ser_force = 1'b1;
  logic        ser_val   = 1'b0;
  int unsigned ser_len   = 4;
  int unsigned ser_left  = 0;

  display_frame_scheduler #(
    .GAP_TICKS    (GapTicks),
    .TIMEOUT_TICKS(TimeoutTicks)
`ifdef DISP_SCHED_REFRESH_EN
    ,
    .REFRESH_TICKS(16)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .req        (req),
    .bcd0       (bcd0),
    .bcd1       (bcd1),
    .busy_in    (busy_in),
    .ack        (ack),
    .bcd_out    (bcd_out),
    .shift_en   (shift_en),
    .active_src (active_src),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit-rate strobe: one clk high every TickDiv clks.
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick     = (tick_div == TickDiv - 1);
      tick_div = (tick_div + 1) % TickDiv;
    end
  end

  // Serializer model: either forced busy level, or busy for ser_len ticks per accepted enable.
  initial begin
    busy_in = 1'b0;
    forever begin
      @(negedge clk);
      if (ser_force) begin
        busy_in  = ser_val;
        ser_left = 0;
      end else if (ser_left != 0) begin
        if (tick) begin
          ser_left--;
          if (ser_left == 0) busy_in = 1'b0;
        end
      end else if (shift_en) begin
        busy_in  = 1'b1;
        ser_left = ser_len;
      end else begin
        busy_in = 1'b0;
      end
    end
  end

  // Output monitor: logs acks, timeouts and enable pulses with their tick index.
  initial begin
    obs_t o;
    ack_prev  = 2'b00;
    terr_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ack != 2'b00) begin
        o.ack      = ack;
        o.src      = active_src;
        o.bcd      = bcd_out;
        o.tick_idx = tick_cnt;
        obs_q.push_back(o);
        if (ack_prev != 2'b00) ack_long++;
      end
      if (timeout_err === 1'b1) begin
        terr_q.push_back(tick_cnt);
        if (terr_prev) terr_long++;
      end
      if (shift_en === 1'b1) begin
        shift_cnt++;
        last_shift_tick = tick_cnt;
        if (!tick) stray_shift++;
      end
      if (tick) tick_cnt++;
      ack_prev  = ack;
      terr_prev = timeout_err;
    end
  end

  function automatic exp_t mk_exp(input logic [1:0] a, input logic [15:0] b);
    exp_t e;
    e.ack = a;
    e.bcd = b;
    return e;
  endfunction

  task automatic wait_ack(input int budget, output bit found, output obs_t o);
    found      = 1'b0;
    o.ack      = 2'b00;
    o.src      = 1'b0;
    o.bcd      = 16'h0;
    o.tick_idx = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk);
      #1;
      if (obs_q.size() != 0) begin
        o     = obs_q.pop_front();
        found = 1'b1;
      end
    end
  endtask

  task automatic pulse_reset();
    req   = 2'b00;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic idle_wait();
    repeat ((GapTicks + 4) * TickDiv) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ser_force = 1'b1;
    ser_val   = 1'b0;
    pulse_reset();
    @(negedge clk);
    checks++;
    if (ack !== 2'b00) begin
      errors++;
      $display("FAIL reset_ack: got %b expected 00", ack);
    end
    checks++;
    if (bcd_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_bcd_out: got %h expected 0000", bcd_out);
    end
    checks++;
    if (active_src !== 1'b1) begin
      errors++;
      $display("FAIL reset_active_src: got %b expected 1", active_src);
    end
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_timeout_err: got %b expected 0", timeout_err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_send();
    int unsigned sc0;
    ser_force = 1'b1;
    ser_val   = 1'b1;
    bcd1      = 16'hABCD;
    req       = 2'b10;
    repeat (20) @(posedge clk);
    #1;
    sc0 = shift_cnt;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (shift_cnt == sc0) begin
      errors++;
      $display("FAIL midsend_frame_active: got %0d enables expected >0", shift_cnt - sc0);
    end
    reset = 1'b0;
    req   = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (shift_en !== 1'b0 || ack !== 2'b00 || bcd_out !== 16'h0 || active_src !== 1'b1) begin
        errors++;
        $display("FAIL midsend_reset cyc%0d: got shift_en=%b ack=%b bcd_out=%h src=%b expected 0 00 0000 1",
                 i, shift_en, ack, bcd_out, active_src);
      end
    end
    reset   = 1'b1;
    ser_val = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (shift_en !== 1'b0) begin
        errors++;
        $display("FAIL midsend_idle_after cyc%0d: got shift_en=%b expected 0", i, shift_en);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL midsend_no_ack: got %0d acks expected 0", obs_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_frame();
    obs_t        o;
    exp_t        e;
    bit          found;
    int unsigned sc0, stray0, gap;
    ser_len   = 32;
    ser_force = 1'b0;
    stray0    = stray_shift;
    bcd0      = 16'h1234;
    req       = 2'b01;
    exp_q.push_back(mk_exp(2'b01, 16'h1234));
    @(posedge clk);
    #1;
    checks++;
    if (bcd_out !== 16'h1234 || active_src !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: got bcd_out=%h src=%b expected 1234 0", bcd_out, active_src);
    end
    wait_ack(2000, found, o);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL single_ack_timeout: got no ack expected ack 01");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (o.ack !== e.ack || o.bcd !== e.bcd || o.src !== 1'b0) begin
        errors++;
        $display("FAIL single_ack: got ack=%b bcd=%h src=%b expected %b %h 0",
                 o.ack, o.bcd, o.src, e.ack, e.bcd);
      end
    end
    // Re-request at once; the next frame must wait out the gap.
    sc0  = shift_cnt;
    bcd0 = 16'h5678;
    exp_q.push_back(mk_exp(2'b01, 16'h5678));
    for (int i = 0; i < 600 && shift_cnt == sc0; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    gap = last_shift_tick - o.tick_idx;
    if (shift_cnt == sc0 || gap < GapTicks) begin
      errors++;
      $display("FAIL single_gap: got %0d ticks expected >= %0d", gap, GapTicks);
    end
    wait_ack(2000, found, o);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL single_ack2_timeout: got no ack expected ack 01");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (o.ack !== e.ack || o.bcd !== e.bcd) begin
        errors++;
        $display("FAIL single_ack2: got ack=%b bcd=%h expected %b %h", o.ack, o.bcd, e.ack, e.bcd);
      end
    end
    req = 2'b00;
    checks++;
    if (stray_shift != stray0) begin
      errors++;
      $display("FAIL single_shift_without_tick: got %0d expected 0", stray_shift - stray0);
    end
    checks++;
    if (ack_long != 0) begin
      errors++;
      $display("FAIL single_ack_width: got %0d long pulses expected 0", ack_long);
    end
    idle_wait();
  endtask

  task automatic test_round_robin();
    obs_t o;
    exp_t e;
    bit   found;
    pulse_reset();
    ser_len   = 4;
    ser_force = 1'b0;
    bcd0      = 16'h1111;
    bcd1      = 16'h2222;
    req       = 2'b11;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) exp_q.push_back(mk_exp(2'b01, 16'h1111));
      else exp_q.push_back(mk_exp(2'b10, 16'h2222));
    end
    for (int k = 0; k < 4; k++) begin
      wait_ack(1000, found, o);
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL rr_ack_timeout grant%0d: got no ack expected one", k);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (o.ack !== e.ack || o.bcd !== e.bcd) begin
          errors++;
          $display("FAIL rr_grant%0d: got ack=%b bcd=%h expected %b %h", k, o.ack, o.bcd, e.ack, e.bcd);
        end
        checks++;
        if (o.ack !== {o.src, ~o.src}) begin
          errors++;
          $display("FAIL rr_ack_vs_src%0d: got ack=%b src=%b expected ack[src] only", k, o.ack, o.src);
        end
      end
    end
    req = 2'b00;
    exp_q.delete();
    idle_wait();
  endtask

  task automatic test_timeout();
    obs_t        o;
    exp_t        e;
    bit          found;
    int unsigned t0;
    ser_force = 1'b1;
    ser_val   = 1'b0;
    bcd0      = 16'h0042;
    req       = 2'b01;
    terr_q.delete();
    obs_q.delete();
    @(posedge clk);
    #1;
    t0 = tick_cnt;
    for (int i = 0; i < (TimeoutTicks + 8) * TickDiv && terr_q.size() == 0; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (terr_q.size() == 0) begin
      errors++;
      $display("FAIL timeout_missing: got no timeout_err expected one");
    end else begin
      checks++;
      if (terr_q[0] != t0 + TimeoutTicks) begin
        errors++;
        $display("FAIL timeout_ticks: got %0d expected %0d", terr_q[0] - t0, TimeoutTicks);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_no_ack: got %0d acks expected 0", obs_q.size());
    end
    checks++;
    if (terr_long != 0) begin
      errors++;
      $display("FAIL timeout_width: got %0d long pulses expected 0", terr_long);
    end
    ser_len   = 4;
    ser_force = 1'b0;
    exp_q.push_back(mk_exp(2'b01, 16'h0042));
    wait_ack(1000, found, o);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL timeout_regrant: got no ack expected ack 01");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (o.ack !== e.ack || o.bcd !== e.bcd) begin
        errors++;
        $display("FAIL timeout_regrant_ack: got ack=%b bcd=%h expected %b %h", o.ack, o.bcd, e.ack, e.bcd);
      end
    end
    req = 2'b00;
    idle_wait();
  endtask

  task automatic test_hold_value();
    obs_t o;
    exp_t e;
    bit   found;
    ser_len   = 16;
    ser_force = 1'b0;
    bcd0      = 16'h1234;
    req       = 2'b01;
    exp_q.push_back(mk_exp(2'b01, 16'h1234));
    repeat (13) @(posedge clk);
    #1;
    bcd0 = 16'h9999;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (bcd_out !== 16'h1234) begin
      errors++;
      $display("FAIL hold_mid_send: got %h expected 1234", bcd_out);
    end
    exp_q.push_back(mk_exp(2'b01, 16'h9999));
    for (int k = 0; k < 2; k++) begin
      wait_ack(1000, found, o);
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL hold_ack_timeout%0d: got no ack expected one", k);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (o.ack !== e.ack || o.bcd !== e.bcd) begin
          errors++;
          $display("FAIL hold_frame%0d: got ack=%b bcd=%h expected %b %h", k, o.ack, o.bcd, e.ack, e.bcd);
        end
      end
    end
    req = 2'b00;
    idle_wait();
  endtask

`ifdef DISP_SCHED_REFRESH_EN
  task automatic test_refresh();
    obs_t        o;
    exp_t        e;
    bit          found;
    int unsigned sc0;
    pulse_reset();
    ser_len   = 4;
    ser_force = 1'b0;
    bcd0      = 16'h4321;
    req       = 2'b01;
    exp_q.push_back(mk_exp(2'b01, 16'h4321));
    wait_ack(1000, found, o);
    req = 2'b00;
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL refresh_first_ack: got no ack expected ack 01");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (o.ack !== e.ack || o.bcd !== e.bcd) begin
        errors++;
        $display("FAIL refresh_first: got ack=%b bcd=%h expected %b %h", o.ack, o.bcd, e.ack, e.bcd);
      end
    end
    sc0 = shift_cnt;
    for (int i = 0; i < 400 && shift_cnt == sc0; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (shift_cnt == sc0 || bcd_out !== 16'h4321 || active_src !== 1'b0) begin
      errors++;
      $display("FAIL refresh_frame: got enables=%0d bcd_out=%h src=%b expected >0 4321 0",
               shift_cnt - sc0, bcd_out, active_src);
    end
    repeat (10 * TickDiv) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL refresh_no_ack: got %0d acks expected 0", obs_q.size());
    end
    bcd1 = 16'h8765;
    req  = 2'b10;
    exp_q.push_back(mk_exp(2'b10, 16'h8765));
    wait_ack(1000, found, o);
    req = 2'b00;
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL refresh_real_ack: got no ack expected ack 10");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (o.ack !== e.ack || o.bcd !== e.bcd) begin
        errors++;
        $display("FAIL refresh_real: got ack=%b bcd=%h expected %b %h", o.ack, o.bcd, e.ack, e.bcd);
      end
    end
    idle_wait();
  endtask
`endif

  initial begin
    reset = 1'b0;
    req   = 2'b00;
    bcd0  = 16'h0;
    bcd1  = 16'h0;
    test_reset();
    test_reset_mid_send();
`ifdef DISP_SCHED_REFRESH_EN
    test_refresh();
`else
    test_single_frame();
    test_round_robin();
    test_timeout();
    test_hold_value();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
